// File: rtl/pll_tap_select.sv
// rtl/pll_tap_select.sv - glitch-free clock-enable tap selector with PLL lock gating
// Tap changes land only on an active-rate pulse so the enable stream never gets denser than either rate.
module pll_tap_select #(
    parameter int LOCK_CYCLES = 1600
) (
    input  logic       i_clock_160,
    input  logic       i_nres,
    input  logic       i_cfg_wr,
    input  logic       i_cfg_pllena,
    input  logic [2:0] i_cfg_clksel,
    output logic       o_clk_en,
    output logic [2:0] o_active_sel,
    output logic       o_pll_ready,
    output logic       o_busy
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    localparam logic [15:0] LOCK_VAL = 16'(LOCK_CYCLES);

    state_t      r_state;
    logic [4:0]  r_div_cnt;
    logic [2:0]  r_active_sel;
    logic [2:0]  r_pending_sel;
    logic        r_pllena;
    logic [15:0] r_lock_cnt;

    logic [5:0]  w_div;
    logic [4:0]  w_mask;
    logic        w_clk_en;
    logic        w_pll_ready;
    logic        w_switch;
    logic [2:0]  w_active_next;
    logic        w_pllena_next;
    logic        w_sel_valid;
    logic        w_force;

    // Divisor mask has log2(D) low ones; sel5 gives an empty mask, i.e. enable every cycle.
    assign w_div         = 6'd32 >> r_active_sel;
    assign w_mask        = 5'(w_div - 6'd1);
    assign w_clk_en      = &(r_div_cnt | ~w_mask);
    assign w_pll_ready   = r_pllena && (r_lock_cnt == LOCK_VAL);
    assign w_switch      = (r_state == S_PENDING) && w_clk_en &&
                           ((r_pending_sel == 3'd0) || w_pll_ready);
    assign w_active_next = w_switch ? r_pending_sel : r_active_sel;
    assign w_pllena_next = i_cfg_wr ? i_cfg_pllena : r_pllena;
    assign w_sel_valid   = (i_cfg_clksel <= 3'd5);
    // Losing the PLL while on a PLL tap must fall back to tap 0, whatever else was written.
    assign w_force       = !w_pllena_next && (w_active_next != 3'd0);

    always_ff @(posedge i_clock_160) begin
        if (!i_nres) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= 5'd0;
            r_active_sel  <= 3'd0;
            r_pending_sel <= 3'd0;
            r_pllena      <= 1'b0;
            r_lock_cnt    <= 16'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 5'd1;
            r_pllena  <= w_pllena_next;

            if (!r_pllena) begin
                r_lock_cnt <= 16'd0;
            end else if (r_lock_cnt != LOCK_VAL) begin
                r_lock_cnt <= r_lock_cnt + 16'd1;
            end

            r_active_sel <= w_active_next;
            if (w_switch) begin
                r_state <= S_IDLE;
            end

            // Writes are judged against the post-switch tap so a same-cycle switch is not undone.
            if (i_cfg_wr && w_sel_valid) begin
                if (i_cfg_clksel == w_active_next) begin
                    r_state <= S_IDLE;
                end else begin
                    r_state       <= S_PENDING;
                    r_pending_sel <= i_cfg_clksel;
                end
            end

            if (w_force) begin
                r_state       <= S_PENDING;
                r_pending_sel <= 3'd0;
            end
        end
    end

    assign o_clk_en     = w_clk_en;
    assign o_active_sel = r_active_sel;
    assign o_pll_ready  = w_pll_ready;
    assign o_busy       = (r_state == S_PENDING);

endmodule

// File: tb/tb_pll_tap_select.sv
// tb/tb_pll_tap_select.sv - directed table-driven bench for pll_tap_select
module tb_pll_tap_select;

    logic       clk = 1'b0;
    logic       nres;
    logic       cfg_wr;
    logic       cfg_pllena;
    logic [2:0] cfg_clksel;
    logic       clk_en;
    logic [2:0] active_sel;
    logic       pll_ready;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    pll_tap_select #(.LOCK_CYCLES(16)) dut (
        .i_clock_160  (clk),
        .i_nres       (nres),
        .i_cfg_wr     (cfg_wr),
        .i_cfg_pllena (cfg_pllena),
        .i_cfg_clksel (cfg_clksel),
        .o_clk_en     (clk_en),
        .o_active_sel (active_sel),
        .o_pll_ready  (pll_ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       pllena;
        logic [2:0] clksel;
        int         gap;
        logic [2:0] act;
        logic       bsy;
        logic       rdy;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic p, input logic [2:0] s);
        cfg_wr     = 1'b1;
        cfg_pllena = p;
        cfg_clksel = s;
        step();
        cfg_wr     = 1'b0;
    endtask

    task automatic next_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!clk_en && n < 100);
        if (!clk_en) n = 999;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!pll_ready && n < 100) begin
            step();
            n++;
        end
        if (!pll_ready) n = 999;
    endtask

    initial begin
        int n;
        int pulses;
        int noisy;

        tbl[0]  = '{1'b0, 1'b0, 3'd0, 15, 3'd0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 3'd0,  4, 3'd3, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 3'd0,  4, 3'd3, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 3'd5,  0, 3'd3, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 3'd1,  0, 3'd3, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 3'd0,  2, 3'd3, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 3'd0,  4, 3'd1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 16, 3'd1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 3'd4,  0, 3'd1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 15, 3'd1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'd0,  2, 3'd4, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 3'd0,  2, 3'd4, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'd4,  0, 3'd4, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 3'd0,  1, 3'd4, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 10, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 3'd0, 32, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 3'd7,  0, 3'd0, 1'b0, 1'b0};

        // Reset held with a write present: the write must be ignored.
        nres       = 1'b0;
        cfg_wr     = 1'b1;
        cfg_pllena = 1'b1;
        cfg_clksel = 3'd3;
        @(negedge clk);
        repeat (3) step();
        chk("rst_clk_en", int'(clk_en), 0);
        chk("rst_active", int'(active_sel), 0);
        chk("rst_ready", int'(pll_ready), 0);
        chk("rst_busy", int'(busy), 0);

        nres   = 1'b1;
        cfg_wr = 1'b0;
        next_pulse(n);
        chk("first_pulse", n, 31);
        next_pulse(n);
        chk("sel0_period", n, 32);
        chk("sel0_active", int'(active_sel), 0);
        chk("sel0_busy", int'(busy), 0);

        // Enable PLL and request tap 3 right at a pulse.
        write(1'b1, 3'd3);
        chk("lock_busy", int'(busy), 1);
        chk("lock_ready0", int'(pll_ready), 0);
        wait_ready(n);
        chk("lock_time", n, 16);
        chk("lock_active_held", int'(active_sel), 0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                write(tbl[i].pllena, tbl[i].clksel);
            end else begin
                next_pulse(n);
                chk($sformatf("vec%0d_gap", i), n, tbl[i].gap);
            end
            chk($sformatf("vec%0d_active", i), int'(active_sel), int'(tbl[i].act));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("vec%0d_ready", i), int'(pll_ready), int'(tbl[i].rdy));
        end

        // Reserved tap write still started the lock count.
        wait_ready(n);
        chk("rsvd_lock_time", n, 16);
        chk("rsvd_busy", int'(busy), 0);

        // Reset in the middle of a pending switch with lock count at 10.
        write(1'b0, 3'd0);
        chk("drop_ready", int'(pll_ready), 0);
        write(1'b1, 3'd2);
        chk("pend_busy", int'(busy), 1);
        write(1'b1, 3'd6);
        chk("pend_rsvd_busy", int'(busy), 1);
        repeat (9) step();
        chk("pend_ready", int'(pll_ready), 0);
        chk("pend_active", int'(active_sel), 0);

        nres       = 1'b0;
        cfg_wr     = 1'b1;
        cfg_pllena = 1'b1;
        cfg_clksel = 3'd3;
        step();
        chk("rst2_clk_en", int'(clk_en), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_ready", int'(pll_ready), 0);
        chk("rst2_active", int'(active_sel), 0);
        nres   = 1'b1;
        cfg_wr = 1'b0;

        pulses = 0;
        noisy  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (clk_en) pulses++;
            if (pll_ready || busy || active_sel != 3'd0) noisy++;
        end
        chk("post_rst_pulses", pulses, 1);
        chk("post_rst_quiet", noisy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
